huffman_seq: RTL and testbench

Sequencer for the Huffman encoder datapath. It tracks the gray-data burst and pulses `CNT_valid` when the burst ends. It then issues the sort, merge, insert and split operations to the shared sort/merge datapath one at a time over a req/ack handshake, and pulses `code_valid` when code generation completes. It replaces the inline FSM in the top level and owns all sequencing; the datapath only executes single operations.

---
 rtl/huffman_seq.sv | 172 +++++++++++++++++
 tb/tb_huffman_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_seq.sv
// Huffman encoder sequencer: records the gray-data burst, then issues SORT/MERGE/INSERT/SPLIT
// ops to the shared datapath over op_req/dp_ack. Optional request timeout: HUFF_SEQ_TIMEOUT_EN.
module huffman_seq #(
    parameter int NSYM    = 6,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gray_valid,
    input  logic       dp_ack,
    output logic       CNT_valid,
    output logic       op_req,
    output logic [2:0] op_code,
    output logic [2:0] round,
    output logic       code_valid,
    output logic       busy,
    output logic [7:0] rec_len,
    output logic       err,
    output logic [2:0] state_dbg
);

    // Handshake: op_req holds op_code/round stable until a cycle with dp_ack=1 (the op is done);
    // op_req then drops for exactly one GAP cycle before the next op is presented.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REC  = 3'd1,
        S_CNT  = 3'd2,
        S_REQ  = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_SORT   = 3'd1,
        OP_MERGE  = 3'd2,
        OP_INSERT = 3'd3,
        OP_SPLIT  = 3'd4
    } op_t;

    localparam logic [2:0] LAST_ROUND = 3'(NSYM - 1);

    if (NSYM < 2 || NSYM > 7 || TIMEOUT < 1) begin : g_bad_param
        $error("huffman_seq: NSYM must be 2..7 and TIMEOUT at least 1");
    end

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [2:0] round_q, round_d;
    logic [7:0] rec_len_q, rec_len_d;

`ifdef HUFF_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q != S_REQ) begin
            tmo_d = '0;
        end else if (!dp_ack) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        round_d   = round_q;
        rec_len_d = rec_len_q;
        case (state_q)
            S_IDLE: begin
                if (gray_valid) begin
                    state_d   = S_REC;
                    rec_len_d = 8'd1;
                end
            end
            S_REC: begin
                if (gray_valid) begin
                    if (rec_len_q != 8'hFF) rec_len_d = rec_len_q + 8'd1;
                end else begin
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                state_d = S_REQ;
                op_d    = OP_SORT;
                round_d = 3'd0;
            end
            S_REQ: begin
                // A late ack in the final allowed cycle still wins over the timeout.
                if (dp_ack) begin
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    op_d    = OP_NONE;
                    round_d = 3'd0;
                end
            end
            S_GAP: begin
                state_d = S_REQ;
                case (op_q)
                    OP_SORT: begin
                        op_d    = OP_MERGE;
                        round_d = 3'd1;
                    end
                    OP_MERGE: begin
                        if (round_q == LAST_ROUND) begin
                            op_d    = OP_SPLIT;
                            round_d = 3'd0;
                        end else begin
                            op_d = OP_INSERT;
                        end
                    end
                    OP_INSERT: begin
                        op_d    = OP_MERGE;
                        round_d = round_q + 3'd1;
                    end
                    default: begin
                        state_d = S_DONE;
                        op_d    = OP_NONE;
                        round_d = 3'd0;
                    end
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NONE;
            round_q   <= 3'd0;
            rec_len_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            round_q   <= round_d;
            rec_len_q <= rec_len_d;
        end
    end

    assign CNT_valid  = (state_q == S_CNT);
    assign op_req     = (state_q == S_REQ);
    assign op_code    = op_q;
    assign round      = round_q;
    assign code_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rec_len    = rec_len_q;
    assign state_dbg  = state_q;
`ifdef HUFF_SEQ_TIMEOUT_EN
    assign err = (state_q == S_ERR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_seq.sv
// Self-checking bench for huffman_seq: expected op sequence queued per run, compared as ops issue.
module tb_huffman_seq;

    localparam int NSYM    = 6;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       gray_valid = 1'b0;
    logic       dp_ack = 1'b0;
    logic       CNT_valid, op_req, code_valid, busy, err;
    logic [2:0] op_code, round, state_dbg;
    logic [7:0] rec_len;

    huffman_seq #(.NSYM(NSYM), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .dp_ack(dp_ack),
        .CNT_valid(CNT_valid), .op_req(op_req), .op_code(op_code), .round(round),
        .code_valid(code_valid), .busy(busy), .rec_len(rec_len), .err(err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int         n_checks = 0;
    int         n_errs = 0;
    logic [5:0] exp_q[$];
    logic [5:0] cur_op = '0;
    logic [5:0] exp_op;
    int         n_cnt = 0, n_code = 0, n_err = 0, cnt_cyc = 0, code_cyc = 0;
    int         fall_cyc = 0;
    int         exp_err = 0;
    logic       prev_req = 1'b0;
    logic       acc_q = 1'b0;

    // datapath responder: 0 = ack tied high, 1 = ack in the ack_at-th REQ cycle, 2 = ack_force
    int   ack_mode = 0;
    int   ack_at = 4;
    int   req_cnt = 0;
    logic ack_force = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        req_cnt = op_req ? req_cnt + 1 : 0;
        case (ack_mode)
            0:       dp_ack = 1'b1;
            1:       dp_ack = op_req && (req_cnt >= ack_at);
            default: dp_ack = ack_force;
        endcase
    end

    always @(posedge clk) acc_q <= op_req & dp_ack;

    // output monitor
    always @(negedge clk) begin
        if (CNT_valid) begin
            n_cnt++;
            cnt_cyc = cyc;
        end
        if (code_valid) begin
            n_code++;
            code_cyc = cyc;
        end
        if (err) n_err++;
        if (acc_q) check_eq("req_drop_after_ack", {31'b0, op_req}, 32'd0);
        if (op_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                check_eq("op_unexpected", exp_q.size(), 32'd1);
            end else begin
                exp_op = exp_q.pop_front();
                check_eq("op_order", {26'b0, op_code, round}, {26'b0, exp_op});
            end
            cur_op = {op_code, round};
        end else if (op_req && prev_req && !acc_q) begin
            check_eq("op_stable", {26'b0, op_code, round}, {26'b0, cur_op});
        end
        prev_req = op_req;
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_ops();
        exp_q.push_back({3'd1, 3'd0});
        for (int r = 1; r <= NSYM - 2; r++) begin
            exp_q.push_back({3'd2, 3'(r)});
            exp_q.push_back({3'd3, 3'(r)});
        end
        exp_q.push_back({3'd2, 3'(NSYM - 1)});
        exp_q.push_back({3'd4, 3'd0});
    endtask

    task automatic burst(input int n);
        gray_valid = 1'b1;
        repeat (n) step();
        gray_valid = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_code(input int budget);
        int start;
        int i;
        start = n_code;
        i = 0;
        while (n_code == start && i < budget) begin
            step();
            i++;
        end
        check_eq("code_valid_seen", n_code - start, 32'd1);
    endtask

    task automatic wait_req(input int budget);
        int i;
        i = 0;
        while (!op_req && i < budget) begin
            step();
            i++;
        end
        check_eq("op_req_seen", {31'b0, op_req}, 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n_prev;
        int k;
        int err_prev;
        int code_prev;
        logic found;

        step();
        step();
        check_eq("reset_outs", {14'b0, CNT_valid, op_req, op_code, round, code_valid, busy,
                 rec_len, err}, 32'd0);
        reset = 1'b1;
        step();

        // burst of 10 with ack tied high: latency and counting
        ack_mode = 0;
        push_ops();
        burst(10);
        wait_code(100);
        check_eq("rec_len_10", rec_len, 32'd10);
        check_eq("cnt_valid_count", n_cnt, 32'd1);
        check_eq("cnt_valid_timing", cnt_cyc, fall_cyc + 1);
        check_eq("code_latency", code_cyc - cnt_cyc, 32'(2 * (2 * NSYM - 1) + 1));
        step();
        check_eq("busy_after_done", {31'b0, busy}, 32'd0);
        check_eq("ops_consumed_1", exp_q.size(), 32'd0);

        // delayed ack: op order and stability
        ack_mode = 1;
        ack_at = 4;
        push_ops();
        burst(5);
        wait_code(200);
        check_eq("rec_len_5", rec_len, 32'd5);
        check_eq("cnt_valid_count2", n_cnt, 32'd2);
        check_eq("ops_consumed_2", exp_q.size(), 32'd0);

        // saturation, gray_valid ignored during REQ
        step();
        push_ops();
        burst(300);
        wait_req(20);
        gray_valid = 1'b1;
        step();
        step();
        gray_valid = 1'b0;
        wait_code(200);
        check_eq("rec_len_sat", rec_len, 32'd255);
        check_eq("cnt_valid_count3", n_cnt, 32'd3);
        check_eq("ops_consumed_3", exp_q.size(), 32'd0);

        // dp_ack in IDLE does nothing
        ack_mode = 2;
        ack_force = 1'b1;
        repeat (4) step();
        check_eq("idle_ack_busy", {31'b0, busy}, 32'd0);
        check_eq("idle_ack_req", {31'b0, op_req}, 32'd0);
        check_eq("idle_ack_rec_len", rec_len, 32'd255);
        ack_force = 1'b0;

        // asynchronous reset during MERGE 3
        ack_mode = 1;
        ack_at = 4;
        push_ops();
        burst(4);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (op_req && op_code == 3'd2 && round == 3'd3) found = 1'b1;
            else step();
        end
        check_eq("reached_merge3", {31'b0, found}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("reset_mid_outs", {14'b0, CNT_valid, op_req, op_code, round, code_valid, busy,
                 rec_len, err}, 32'd0);
        exp_q.delete();
        step();
        reset = 1'b1;
        step();
        push_ops();
        burst(4);
        wait_code(200);
        check_eq("rec_len_after_reset", rec_len, 32'd4);
        check_eq("ops_consumed_4", exp_q.size(), 32'd0);

        // back-to-back: new burst in the IDLE cycle right after DONE
        ack_mode = 0;
        push_ops();
        burst(3);
        wait_code(100);
        n_prev = n_cnt;
        step();
        push_ops();
        burst(2);
        k = 0;
        while (n_cnt == n_prev && k < 20) begin
            step();
            k++;
        end
        check_eq("b2b_cnt_valid", n_cnt - n_prev, 32'd1);
        wait_code(100);
        check_eq("b2b_rec_len", rec_len, 32'd2);
        check_eq("ops_consumed_5", exp_q.size(), 32'd0);

`ifdef HUFF_SEQ_TIMEOUT_EN
        // no ack at SORT: request held TIMEOUT cycles, then err
        step();
        ack_mode = 2;
        ack_force = 1'b0;
        err_prev = n_err;
        code_prev = n_code;
        exp_q.push_back({3'd1, 3'd0});
        burst(2);
        wait_req(20);
        k = 0;
        while (op_req && k < 50) begin
            k++;
            step();
        end
        check_eq("tmo_req_cycles", k, 32'(TIMEOUT));
        step();
        check_eq("tmo_err_pulses", n_err - err_prev, 32'd1);
        check_eq("tmo_busy", {31'b0, busy}, 32'd0);
        check_eq("tmo_no_code", n_code - code_prev, 32'd0);
        exp_err = 1;

        // ack in the last allowed cycle is accepted
        ack_mode = 1;
        ack_at = TIMEOUT;
        err_prev = n_err;
        push_ops();
        burst(2);
        wait_code(400);
        check_eq("late_ack_no_err", n_err - err_prev, 32'd0);
        check_eq("ops_consumed_tmo", exp_q.size(), 32'd0);
`endif

        step();
        check_eq("err_pulses_total", n_err, exp_err);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
